// File: rtl/sp_sequencer_if.sv
// sp_sequencer_if
//   Requester handshake and memory strobe bundle for sp_sequencer.
//   Requester side : op_valid, op_code -> ; <- op_ready, op_done, op_err
//   Memory side    : mem_ack ->          ; <- mem_wr, mem_rd
//   slave  : sequencer view
//   master : requester/memory (testbench) view
interface sp_sequencer_if;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;
  logic       op_done;
  logic       op_err;
  logic       mem_ack;
  logic       mem_wr;
  logic       mem_rd;

  modport slave (
    input  op_valid, op_code, mem_ack,
    output op_ready, op_done, op_err, mem_wr, mem_rd
  );

  modport master (
    output op_valid, op_code, mem_ack,
    input  op_ready, op_done, op_err, mem_wr, mem_rd
  );
endinterface

// File: rtl/sp_sequencer.sv
// sp_sequencer
//   Stack-pointer sequencer: turns PUSH/POP/LOAD/READ requests into a fixed
//   sequence of stack-pointer controls and memory strobes, tracking depth.
//   Ports:
//     clk           sole clock, rising edge
//     reset         asynchronous, active-low reset
//     bus (slave)   op_valid/op_code/op_ready/op_done/op_err, mem_ack/mem_wr/mem_rd
//     sp_write, sp_inc, sp_dec, sp_read_abus, sp_read_dbus   stack-pointer controls
//     fault         sticky bounds-violation flag
//     depth         current stack depth
//   Optional feature: define SP_BOUNDS_CHECK_EN to reject PUSH at full depth
//   and POP at empty (op_err + sticky fault). Without it the depth counter
//   wraps and op_err/fault are tied low.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | ready for a new operation
//   DEC    | PUSH: pre-decrement stack pointer
//   MEMW   | PUSH: write memory at SP until mem_ack
//   MEMR   | POP: read memory at SP until mem_ack
//   INC    | POP: post-increment stack pointer
//   LOAD   | write stack pointer, clear depth and fault
//   RDSP   | drive stack pointer onto data bus
//   DONE   | one-cycle completion pulse
module sp_sequencer #(
  parameter  int STACK_DEPTH = 256,
  localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  sp_sequencer_if.slave bus,
  output logic          sp_write,
  output logic          sp_inc,
  output logic          sp_dec,
  output logic          sp_read_abus,
  output logic          sp_read_dbus,
  output logic          fault,
  output logic [DW-1:0] depth
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_DEC, S_MEMW, S_MEMR, S_INC, S_LOAD, S_RDSP, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_depth;
  logic          w_accept;
  logic          w_push_err;
  logic          w_pop_err;
  logic          w_done;

  assign w_accept = (r_state == S_IDLE) && bus.op_valid;

`ifdef SP_BOUNDS_CHECK_EN
  logic r_err;
  logic r_fault;

  assign w_push_err = (r_depth == DW'(STACK_DEPTH));
  assign w_pop_err  = (r_depth == '0);

  // r_err holds the verdict of the accepted operation until its DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err <= ((bus.op_code == OP_PUSH) && w_push_err) ||
                 ((bus.op_code == OP_POP)  && w_pop_err);
      end
      if (w_accept && (((bus.op_code == OP_PUSH) && w_push_err) ||
                       ((bus.op_code == OP_POP)  && w_pop_err))) begin
        r_fault <= 1'b1;
      end else if (r_state == S_LOAD) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign fault      = r_fault;
  assign bus.op_err = w_done && r_err;
`else
  assign w_push_err = 1'b0;
  assign w_pop_err  = 1'b0;
  assign fault      = 1'b0;
  assign bus.op_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Depth moves only on completion of the memory/pointer step so it is
  // stable throughout an operation and updated by its DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (r_state == S_LOAD) begin
      r_depth <= '0;
    end else if ((r_state == S_MEMW) && bus.mem_ack) begin
      r_depth <= r_depth + DW'(1);
    end else if (r_state == S_INC) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign depth = r_depth;

  always_comb begin
    w_next       = r_state;
    bus.op_ready = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_rd   = 1'b0;
    w_done       = 1'b0;
    sp_write     = 1'b0;
    sp_inc       = 1'b0;
    sp_dec       = 1'b0;
    sp_read_abus = 1'b0;
    sp_read_dbus = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        bus.op_ready = 1'b1;
        if (bus.op_valid) begin
          unique case (bus.op_code)
            OP_PUSH: w_next = w_push_err ? S_DONE : S_DEC;
            OP_POP:  w_next = w_pop_err  ? S_DONE : S_MEMR;
            OP_LOAD: w_next = S_LOAD;
            default: w_next = S_RDSP;
          endcase
        end
      end
      S_DEC: begin
        sp_dec = 1'b1;
        w_next = S_MEMW;
      end
      S_MEMW: begin
        sp_read_abus = 1'b1;
        bus.mem_wr   = 1'b1;
        if (bus.mem_ack) w_next = S_DONE;
      end
      S_MEMR: begin
        sp_read_abus = 1'b1;
        bus.mem_rd   = 1'b1;
        if (bus.mem_ack) w_next = S_INC;
      end
      S_INC: begin
        sp_inc = 1'b1;
        w_next = S_DONE;
      end
      S_LOAD: begin
        sp_write = 1'b1;
        w_next   = S_DONE;
      end
      S_RDSP: begin
        sp_read_dbus = 1'b1;
        w_next       = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.op_done = w_done;

endmodule

// File: doc/sp_sequencer.md
SP_SEQUENCER -- requirements
Module: sp_sequencer

Interface
REQ-001 The block SHALL have parameter STACK_DEPTH, default 256, meaning the maximum number of entries pushed before overflow; the depth counter width SHALL be $clog2(STACK_DEPTH+1).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port op_valid  input  1  requester presents an operation.
REQ-005 The block SHALL have port op_code  input  2  operation: 00 PUSH, 01 POP, 10 LOAD, 11 READ.
REQ-006 The block SHALL have port op_ready  output  1  high only in IDLE.
REQ-007 The block SHALL have port op_done  output  1  one-cycle completion pulse.
REQ-008 The block SHALL have port op_err  output  1  qualifies op_done; operation rejected by bounds check.
REQ-009 The block SHALL have port mem_ack  input  1  memory completed the current read/write.
REQ-010 The block SHALL have ports mem_wr, mem_rd  output  1 each  memory strobes, held until mem_ack.
REQ-011 The block SHALL have ports sp_write, sp_inc, sp_dec, sp_read_abus, sp_read_dbus  output  1 each  stack-pointer controls.
REQ-012 The block SHALL have port fault  output  1  sticky bounds-violation flag.

Function
REQ-013 Transfer SHALL occur on a clk edge with op_valid=1 and op_ready=1; op_code is sampled then. op_valid SHALL be ignored otherwise.
REQ-014 States: IDLE, DEC, MEMW, MEMR, INC, LOAD, RDSP, DONE; all outputs SHALL be Moore, decoded from state only.
REQ-015 PUSH: IDLE -> DEC (sp_dec=1, one cycle) -> MEMW (sp_read_abus=1, mem_wr=1 until mem_ack sampled high) -> DONE.
REQ-016 POP: IDLE -> MEMR (sp_read_abus=1, mem_rd=1 until mem_ack sampled high) -> INC (sp_inc=1, one cycle) -> DONE.
REQ-017 LOAD: IDLE -> LOAD (sp_write=1, one cycle; depth cleared to 0; fault cleared) -> DONE.
REQ-018 READ: IDLE -> RDSP (sp_read_dbus=1, one cycle) -> DONE.
REQ-019 DONE SHALL assert op_done for exactly one cycle and return to IDLE; back-to-back ops SHALL therefore have one IDLE cycle between them.
REQ-020 With mem_ack high in the first memory cycle, op_done SHALL appear in the 3rd cycle after acceptance for PUSH and POP, and in the 2nd for LOAD and READ; each mem_ack-low cycle SHALL add one cycle.
REQ-021 At most one of sp_write, sp_inc, sp_dec, sp_read_abus, sp_read_dbus SHALL be high in any cycle; mem_wr and mem_rd SHALL never both be high.
REQ-022 mem_ack SHALL be ignored outside MEMW/MEMR.
REQ-023 Depth counter SHALL increment when leaving MEMW and decrement when leaving INC.

Reset
REQ-024 reset low SHALL immediately force state IDLE, depth 0, fault 0, and every output 0 except op_ready, which SHALL be 1 once reset is released.
REQ-025 Reset asserted mid-operation SHALL abandon the operation with no op_done pulse; memory strobes SHALL drop asynchronously.

Configuration
REQ-026 With macro SP_BOUNDS_CHECK_EN defined, a PUSH accepted at depth==STACK_DEPTH, or a POP accepted at depth==0, SHALL go directly IDLE -> DONE with no sp_* or mem_* strobes, op_err=1 during op_done, and fault set until LOAD or reset.
REQ-027 Without SP_BOUNDS_CHECK_EN, no bounds check SHALL occur: op_err and fault SHALL be tied 0, and the depth counter SHALL wrap modulo 2^width.

Verification
REQ-028 Reset, then LOAD -> sp_write high 1 cycle, op_done 2 cycles after accept, op_err=0, depth=0.
REQ-029 PUSH with mem_ack held high -> sp_dec 1 cycle, then sp_read_abus+mem_wr 1 cycle, op_done 3rd cycle after accept; depth=1.
REQ-030 POP with mem_ack delayed 3 cycles -> mem_rd+sp_read_abus high 4 cycles, then sp_inc 1 cycle, op_done 6th cycle after accept; depth=0.
REQ-031 SP_BOUNDS_CHECK_EN set, POP at depth 0 -> no strobes, op_done+op_err 1 cycle after accept, fault=1 until next LOAD. With STACK_DEPTH=2, a 3rd PUSH -> same error response.
REQ-032 reset pulsed low while in MEMW -> mem_wr drops without waiting for clk, no op_done, op_ready=1 after release.
